// File: rtl/tt6581_voice_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tt6581_voice_sched                                                |
// | Sample-rate tick generator and voice/mix sequencer for the synth core.     |
// | Optional watchdog enabled by defining TT6581_SCHED_WDOG_EN.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tt6581_voice_sched #(
   parameter int NUM_VOICES  = 3,
   parameter int SAMPLE_DIV  = 1042,
   parameter int WDOG_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic voice_req_o,
   output logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] voice_idx_o,
   input  logic voice_ack_i,
   output logic mix_req_o,
   input  logic mix_ack_i,
   output logic sample_tick_o,
   output logic sample_valid_o,
   output logic busy_o,
   output logic overrun_o,
   output logic timeout_o,
   input  logic status_clr_i
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_VOICES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_VOICE = 2'd1,
      S_MIX   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_div;
   logic             r_tick;
   logic [IDX_W-1:0] r_idx;
   logic             r_voice_req;
   logic             r_mix_req;
   logic             r_valid;
   logic             r_busy;
   logic             r_overrun;
   logic             r_timeout;
   logic             w_wdog_exp;

`ifdef TT6581_SCHED_WDOG_EN
   localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] c_WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] r_wdog;

   assign w_wdog_exp = (r_wdog == c_WDOG_LAST) &&
                       (((r_state == S_VOICE) && !voice_ack_i) ||
                        ((r_state == S_MIX) && !mix_ack_i));

   // Wait counter restarts on every state entry and accepted ack
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wdog <= '0;
      end else if ((r_state == S_IDLE) || (r_state == S_DONE) || w_wdog_exp ||
                   ((r_state == S_VOICE) && voice_ack_i) ||
                   ((r_state == S_MIX) && mix_ack_i)) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + WD_W'(1);
      end
   end
`else
   assign w_wdog_exp = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if (!en_i) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if (r_div == c_DIV_LAST) begin
         r_div  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_div  <= r_div + CNT_W'(1);
         r_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_voice_req <= 1'b0;
         r_mix_req   <= 1'b0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_tick) begin
                  r_state     <= S_VOICE;
                  r_idx       <= '0;
                  r_voice_req <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            S_VOICE: begin
               if (voice_ack_i) begin
                  if (r_idx == c_IDX_LAST) begin
                     r_idx       <= '0;
                     r_voice_req <= 1'b0;
                     r_mix_req   <= 1'b1;
                     r_state     <= S_MIX;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else if (w_wdog_exp) begin
                  r_idx       <= '0;
                  r_voice_req <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_MIX: begin
               if (mix_ack_i) begin
                  r_mix_req <= 1'b0;
                  r_valid   <= 1'b1;
                  r_state   <= S_DONE;
               end else if (w_wdog_exp) begin
                  r_mix_req <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky status: a set event in the same cycle as a clear takes priority
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (r_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end else if (status_clr_i) begin
            r_overrun <= 1'b0;
         end
         if (w_wdog_exp) begin
            r_timeout <= 1'b1;
         end else if (status_clr_i) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign voice_req_o    = r_voice_req;
   assign voice_idx_o    = r_idx;
   assign mix_req_o      = r_mix_req;
   assign sample_tick_o  = r_tick;
   assign sample_valid_o = r_valid;
   assign busy_o         = r_busy;
   assign overrun_o      = r_overrun;
   assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_tt6581_voice_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tt6581_voice_sched                                             |
// | Scoreboard bench for tt6581_voice_sched (SAMPLE_DIV=8, NUM_VOICES=3).      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_tt6581_voice_sched;

   localparam int NV  = 3;
   localparam int DIV = 8;
   localparam int WD  = 16;

   logic       clk_i = 1'b0;
   logic       rst_i, en_i, voice_ack_i, mix_ack_i, status_clr_i;
   logic       voice_req_o, mix_req_o, sample_tick_o, sample_valid_o;
   logic       busy_o, overrun_o, timeout_o;
   logic [1:0] voice_idx_o;

   tt6581_voice_sched #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV), .WDOG_CYCLES(WD)) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .voice_req_o   (voice_req_o),
      .voice_idx_o   (voice_idx_o),
      .voice_ack_i   (voice_ack_i),
      .mix_req_o     (mix_req_o),
      .mix_ack_i     (mix_ack_i),
      .sample_tick_o (sample_tick_o),
      .sample_valid_o(sample_valid_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .timeout_o     (timeout_o),
      .status_clr_i  (status_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Expected event stream: voice indices, then 100 = mix, 200 = sample valid
   int q[$];
   int n_chk = 0, n_err = 0;
   int cyc = 0, last_tick = -1, tick_cyc = 0;
   int vdelay = 0, mdelay = 0, vcnt = 0, mcnt = 0;
   bit seq_active = 0, exp_ovr = 0, spur = 0, idle_spur = 0, clr_req = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      cyc++;
      voice_ack_i  = 1'b0;
      mix_ack_i    = 1'b0;
      status_clr_i = clr_req;
      clr_req      = 1'b0;
      if (sample_tick_o) begin
         if (last_tick >= 0) chk("tick_period", cyc - last_tick, DIV);
         last_tick = cyc;
         if (seq_active) begin
            exp_ovr = 1'b1;
         end else begin
            seq_active = 1'b1;
            tick_cyc   = cyc;
            for (int i = 0; i < NV; i++) q.push_back(i);
            q.push_back(100);
            q.push_back(200);
         end
      end else if (status_clr_i) begin
         exp_ovr = 1'b0;
      end
      if (voice_req_o) begin
         chk("req_exclusive", mix_req_o, 0);
         if (q.size() == 0) chk("voice_req_unexpected", 1, 0);
         else begin
            chk("voice_idx", voice_idx_o, q[0]);
            if (vcnt == vdelay) begin
               voice_ack_i = 1'b1;
               void'(q.pop_front());
               vcnt = 0;
            end else begin
               vcnt++;
               if (spur) mix_ack_i = 1'b1;
            end
         end
      end
      if (mix_req_o) begin
         chk("mix_idx_zero", voice_idx_o, 0);
         if (q.size() == 0) chk("mix_req_unexpected", 1, 0);
         else begin
            chk("mix_order", q[0], 100);
            if (mcnt == mdelay) begin
               mix_ack_i = 1'b1;
               void'(q.pop_front());
               mcnt = 0;
            end else begin
               mcnt++;
               if (spur) voice_ack_i = 1'b1;
            end
         end
      end
      if (sample_valid_o) begin
         if (q.size() == 0) chk("valid_unexpected", 1, 0);
         else begin
            chk("valid_order", q.pop_front(), 200);
            if (vdelay == 0 && mdelay == 0) chk("valid_latency", cyc - tick_cyc, NV + 2);
         end
         seq_active = 1'b0;
      end
      if (idle_spur) begin
         voice_ack_i = 1'b1;
         mix_ack_i   = 1'b1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || seq_active) && n < 80) begin
         step();
         n++;
      end
      if (n >= 80) chk("drain_timeout", 1, 0);
      run(2);
   endtask

   task automatic clear_status();
      clr_req = 1'b1;
      run(3);
      chk("overrun_cleared", overrun_o, 0);
      chk("timeout_cleared", timeout_o, 0);
   endtask

   task automatic stop_en();
      en_i      = 1'b0;
      last_tick = -1;
      drain();
   endtask

   initial begin
      int n;
      int rel;
      rst_i = 1'b1; en_i = 1'b0; voice_ack_i = 1'b0; mix_ack_i = 1'b0; status_clr_i = 1'b0;
      run(2);
      chk("reset_outputs", {voice_req_o, mix_req_o, sample_tick_o, sample_valid_o,
                            busy_o, overrun_o, timeout_o, voice_idx_o}, 0);
      rst_i = 1'b0;
      en_i  = 1'b1;

      // Immediate acks, several sample periods
      run(34);
      chk("overrun_idle_t1", overrun_o, 0);

      // Delayed voice acks stretch the sequence past one period
      vdelay = 3;
      run(40);
      stop_en();
      chk("overrun_model_t2", overrun_o, exp_ovr);
      clear_status();
      vdelay = 0;

      // Mix ack withheld: next tick dropped
      en_i = 1'b1;
      mdelay = 10;
      run(24);
      chk("overrun_set_t3", overrun_o, 1);
      chk("timeout_zero_t3", timeout_o, 0);
      mdelay = 0;
      stop_en();
      clear_status();

      // Spurious acks in IDLE
      idle_spur = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("idle_busy", busy_o, 0);
         chk("idle_reqs", {voice_req_o, mix_req_o, sample_valid_o, sample_tick_o}, 0);
         chk("idle_idx", voice_idx_o, 0);
      end
      idle_spur = 1'b0;
      run(1);

      // Wrong-state acks during VOICE and MIX waits
      en_i = 1'b1; spur = 1'b1; vdelay = 2; mdelay = 2;
      run(20);
      stop_en();
      spur = 1'b0; vdelay = 0; mdelay = 0;
      clear_status();

      // Asynchronous reset in the middle of voice 1
      en_i = 1'b1; vdelay = 3; n = 0;
      while (!(voice_req_o && voice_idx_o == 2'd1) && n < 40) begin
         step();
         n++;
      end
      chk("reach_idx1", n < 40, 1);
      #2 rst_i = 1'b1;
      #1 chk("async_reset_outputs", {voice_req_o, mix_req_o, sample_tick_o, sample_valid_o,
                                     busy_o, overrun_o, timeout_o, voice_idx_o}, 0);
      q.delete(); seq_active = 0; vcnt = 0; mcnt = 0; last_tick = -1; exp_ovr = 0; vdelay = 0;
      run(2);
      rst_i = 1'b0;
      rel = cyc;
      n = 0;
      while (last_tick < 0 && n < 20) begin
         step();
         n++;
      end
      chk("tick_after_reset", last_tick - rel, DIV);
      run(8);
      stop_en();

`ifdef TT6581_SCHED_WDOG_EN
      // Never ack: watchdog aborts after WD request cycles
      en_i = 1'b1; vdelay = 1000; n = 0;
      while (!voice_req_o && n < 20) begin
         step();
         n++;
      end
      n = 0;
      while (voice_req_o && n < 40) begin
         step();
         n++;
      end
      chk("wdog_req_cycles", n, WD);
      chk("wdog_timeout", timeout_o, 1);
      chk("wdog_no_valid", sample_valid_o, 0);
      chk("wdog_idx", voice_idx_o, 0);
      q.delete(); seq_active = 0; vcnt = 0; vdelay = 0;
      run(10);
      stop_en();
      clear_status();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
